// File: rtl/task_packer.sv
// task_packer: assembles five 32-bit host words into one 144-bit search task
// and presents it on a valid/ready output with a one-entry output register.
// Word 4 contributes only its low 16 bits (task bits [143:128]).
// Optional framing check against input_last is enabled by defining the
// macro PACKER_LAST_CHECK_EN. When it is enabled, short and long frames are
// dropped and counted in a saturating drop counter. In the default build,
// framing is purely by word count and drop_count is tied to zero.

module task_packer #(
    parameter int WORDS  = 5,
    parameter int DROP_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        input_data,
    input  logic               input_valid,
    output logic               input_ready,
    input  logic               input_last,
    output logic [143:0]       output_data,
    output logic               output_valid,
    input  logic               output_ready,
    output logic [DROP_W-1:0]  drop_count
);

    // The task layout is hard-wired around five words; reject anything else.
    if (WORDS != 5) begin : g_words_check
        $error("task_packer: WORDS must be 5 for the 144-bit task");
    end

    localparam logic [2:0] LAST_IDX = 3'd4;

    logic [2:0]   r_idx;
    logic [127:0] r_asm;
    logic [143:0] r_out_data;
    logic         r_out_valid;

    logic w_in_fire;
    logic w_load;
    logic w_store;
    logic w_wrap;

    // Only word 4 has to wait for the output register; words 0..3 land in
    // the assembly register and can overlap a stalled task.
    assign input_ready = !((r_idx == LAST_IDX) && r_out_valid && !output_ready);
    assign w_in_fire   = input_valid && input_ready;

`ifdef PACKER_LAST_CHECK_EN
    logic              r_skip;
    logic [DROP_W-1:0] r_drop_count;
    logic              w_short;
    logic              w_long;

    // A word marked last before word 4 ends a short frame; word 4 without
    // last starts a long frame whose tail is swallowed until the next last.
    assign w_short = w_in_fire && !r_skip && input_last && (r_idx != LAST_IDX);
    assign w_long  = w_in_fire && !r_skip && !input_last && (r_idx == LAST_IDX);
    assign w_load  = w_in_fire && !r_skip && input_last && (r_idx == LAST_IDX);
    assign w_store = w_in_fire && !r_skip && (r_idx != LAST_IDX);
    assign w_wrap  = w_in_fire && (r_skip || input_last || (r_idx == LAST_IDX));

    // Discard mode for the remainder of a long frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_skip <= 1'b0;
        end else if (w_long) begin
            r_skip <= 1'b1;
        end else if (w_in_fire && r_skip && input_last) begin
            r_skip <= 1'b0;
        end
    end

    // Saturating count of malformed frames.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if ((w_short || w_long) && (r_drop_count != '1)) begin
            r_drop_count <= r_drop_count + 1'b1;
        end
    end

    assign drop_count = r_drop_count;
`else
    logic w_unused;

    assign w_load     = w_in_fire && (r_idx == LAST_IDX);
    assign w_store    = w_in_fire && (r_idx != LAST_IDX);
    assign w_wrap     = w_load;
    assign drop_count = '0;
    // input_last carries no meaning when framing is by word count alone.
    assign w_unused   = &{1'b0, input_last};
`endif

    // Word index within the current frame; returns to 0 at every frame end.
    // NOTE: state registers use non-blocking assignments so every flop in
    // the design samples pre-edge values, independent of block ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx <= '0;
        end else if (w_wrap) begin
            r_idx <= '0;
        end else if (w_in_fire) begin
            r_idx <= r_idx + 3'd1;
        end
    end

    // Assembly register for words 0..3; never cleared between frames, each
    // frame simply overwrites it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_asm <= '0;
        end else if (w_store) begin
            r_asm[{r_idx[1:0], 5'd0} +: 32] <= input_data;
        end
    end

    // Output register: loads on word-4 acceptance, holds while stalled,
    // drops valid after a handshake unless a new task reloads it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= {input_data[15:0], r_asm};
            r_out_valid <= 1'b1;
        end else if (r_out_valid && output_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign output_data  = r_out_data;
    assign output_valid = r_out_valid;

endmodule

// File: tb/tb_task_packer.sv
// Testbench for task_packer: directed scenarios followed by randomized
// traffic, all checked cycle by cycle against a frame/queue level model.
// Define PACKER_LAST_CHECK_EN for both files to exercise framing checks.

module tb_task_packer;

    localparam int DROP_W = 8;

    logic               clock = 1'b0;
    logic               reset;
    logic [31:0]        input_data;
    logic               input_valid;
    logic               input_ready;
    logic               input_last;
    logic [143:0]       output_data;
    logic               output_valid;
    logic               output_ready;
    logic [DROP_W-1:0]  drop_count;

    task_packer #(.WORDS(5), .DROP_W(DROP_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .input_data   (input_data),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_last   (input_last),
        .output_data  (output_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .drop_count   (drop_count)
    );

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_fail = 0;
    int dut_taken = 0;

    // Reference model: words of the frame in progress, tasks awaiting
    // hand-off, and the expected drop count.
    logic [31:0]  frame[$];
    logic [143:0] tq[$];
    int           m_drop = 0;
`ifdef PACKER_LAST_CHECK_EN
    bit           m_skip = 0;
`endif

    task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [143:0] pack_frame();
        return {frame[4][15:0], frame[3], frame[2], frame[1], frame[0]};
    endfunction

    function automatic logic [143:0] mk_task(input logic [31:0] base);
        return {base[15:0] + 16'd4, base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    // One clock cycle: drive inputs after the falling edge, compare DUT
    // outputs against the model, then advance the model by the handshakes
    // the next rising edge will perform.
    task automatic step(input logic v, input logic [31:0] d, input logic l,
                        input logic ordy, input logic rst);
        logic exp_valid;
        logic exp_rdy;
        @(negedge clock);
        input_valid  = v;
        input_data   = d;
        input_last   = l;
        output_ready = ordy;
        reset        = rst;
        #1;
        exp_valid = (tq.size() != 0);
        exp_rdy   = !((frame.size() == 4) && exp_valid && !ordy);
        check("ovalid", {143'd0, output_valid}, {143'd0, exp_valid});
        if (exp_valid) check("odata", output_data, tq[0]);
        check("iready", {143'd0, input_ready}, {143'd0, exp_rdy});
        check("drop", {136'd0, drop_count}, 144'(m_drop));
        if (output_valid && output_ready && !rst) dut_taken++;
        if (rst) begin
            tq.delete();
            frame.delete();
            m_drop = 0;
`ifdef PACKER_LAST_CHECK_EN
            m_skip = 0;
`endif
        end else begin
            if (exp_valid && ordy) void'(tq.pop_front());
            if (v && exp_rdy) begin
`ifdef PACKER_LAST_CHECK_EN
                if (m_skip) begin
                    if (l) m_skip = 0;
                end else begin
                    frame.push_back(d);
                    if (frame.size() == 5) begin
                        if (l) tq.push_back(pack_frame());
                        else begin
                            if (m_drop < (1 << DROP_W) - 1) m_drop++;
                            m_skip = 1;
                        end
                        frame.delete();
                    end else if (l) begin
                        if (m_drop < (1 << DROP_W) - 1) m_drop++;
                        frame.delete();
                    end
                end
`else
                frame.push_back(d);
                if (frame.size() == 5) begin
                    tq.push_back(pack_frame());
                    frame.delete();
                end
`endif
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    endtask

    // Sends one well-formed five-word frame starting at value base.
    task automatic send_frame(input logic [31:0] base, input logic ordy);
        for (int i = 0; i < 5; i++) step(1'b1, base + 32'(i), i == 4, ordy, 1'b0);
    endtask

    initial begin
        int taken0;
        logic [31:0] rd;
        logic rl;

        reset = 1'b1; input_valid = 1'b0; input_data = '0;
        input_last = 1'b0; output_ready = 1'b0;
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        check("rst_valid", {143'd0, output_valid}, 144'd0);
        check("rst_data", output_data, 144'd0);
        check("rst_ready", {143'd0, input_ready}, 144'd1);
        check("rst_drop", {136'd0, drop_count}, 144'd0);

        // Basic task, upper half of word 4 ignored.
        step(1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0002, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0003, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0004, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'hFFFF_0005, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        check("t1_valid", {143'd0, output_valid}, 144'd1);
        check("t1_data", output_data, 144'h0005_00000004_00000003_00000002_00000001);
        idle(2);

        // Back-to-back tasks against a stalled output.
        send_frame(32'hA000_0010, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'hB000_0020 + 32'(i), 1'b0, 1'b0, 1'b0);
            check("t2_rdy_w", {143'd0, input_ready}, 144'd1);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'hB000_0024, 1'b1, 1'b0, 1'b0);
            check("t2_stall", {143'd0, input_ready}, 144'd0);
            check("t2_hold", output_data, mk_task(32'hA000_0010));
        end
        step(1'b1, 32'hB000_0024, 1'b1, 1'b1, 1'b0);
        check("t2_release", {143'd0, input_ready}, 144'd1);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        check("t2_next_valid", {143'd0, output_valid}, 144'd1);
        check("t2_next_data", output_data, mk_task(32'hB000_0020));
        idle(2);

        // Four tasks streamed with no gaps.
        taken0 = dut_taken;
        for (int t = 0; t < 4; t++) send_frame(32'hC000_0000 + 32'(t * 16), 1'b1);
        idle(3);
        check("t3_tasks", 144'(dut_taken - taken0), 144'd4);

`ifdef PACKER_LAST_CHECK_EN
        // Short frame then a good one.
        taken0 = dut_taken;
        for (int i = 0; i < 3; i++) step(1'b1, 32'hD000_0000 + 32'(i), i == 2, 1'b1, 1'b0);
        send_frame(32'hD100_0000, 1'b1);
        idle(2);
        check("t4_drop", {136'd0, drop_count}, 144'd1);
        check("t4_tasks", 144'(dut_taken - taken0), 144'd1);

        // Long frame then a good one.
        taken0 = dut_taken;
        for (int i = 0; i < 7; i++) step(1'b1, 32'hE000_0000 + 32'(i), i == 6, 1'b1, 1'b0);
        idle(2);
        check("t5_drop", {136'd0, drop_count}, 144'd2);
        check("t5_none", 144'(dut_taken - taken0), 144'd0);
        send_frame(32'hE100_0000, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        check("t5_good", output_data, mk_task(32'hE100_0000));
        idle(2);
`endif

        // Reset in the middle of a frame.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h9000_0000 + 32'(i), 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        taken0 = dut_taken;
        send_frame(32'h5000_0000, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        check("t6_data", output_data, mk_task(32'h5000_0000));
        idle(3);
        check("t6_tasks", 144'(dut_taken - taken0), 144'd1);

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 600; i++) begin
            rd = $urandom;
`ifdef PACKER_LAST_CHECK_EN
            rl = (frame.size() == 4) ? ($urandom_range(7) != 0) : ($urandom_range(11) == 0);
`else
            rl = $urandom_range(1);
`endif
            step($urandom_range(3) != 0, rd, rl, $urandom_range(2) != 0, 1'b0);
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
